// File: rtl/ltf_sync_pkg.sv
// Shared types and default constants for the LTF timing-sync controller.
// Optional CONFIRM stage is enabled with LTF_SYNC_CONFIRM_EN.
package ltf_sync_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FLUSH,
    SEARCH,
    CONFIRM,
    DONE
  } state_e;

  localparam int MAG_WIDTH_DEF    = 32;
  localparam int CORR_LATENCY_DEF = 9;
  localparam int WINDOW_DEF       = 64;
  localparam int SPACING_DEF      = 4;
  localparam int TOL_DEF          = 1;
  localparam int IDX_WIDTH_DEF    = 8;

  // Bits needed to hold the values 0..n inclusive.
  function automatic int cnt_bits(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/ltf_peak_tracker.sv
// Running-maximum register for qualified correlator blocks.
// The earliest block keeps the peak on equal magnitudes.
module ltf_peak_tracker
  import ltf_sync_pkg::*;
#(
  parameter int MAG_WIDTH = MAG_WIDTH_DEF,
  parameter int IDX_WIDTH = IDX_WIDTH_DEF
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 clear_i,
  input  logic                 en_i,
  input  logic [MAG_WIDTH-1:0] mag_i,
  input  logic [IDX_WIDTH-1:0] idx_i,
  output logic [MAG_WIDTH-1:0] max_o,
  output logic [IDX_WIDTH-1:0] idx_o,
  output logic                 any_o
);

  logic [MAG_WIDTH-1:0] max_q, max_d;
  logic [IDX_WIDTH-1:0] idx_q, idx_d;
  logic                 any_q, any_d;

  always_comb begin
    max_d = max_q;
    idx_d = idx_q;
    any_d = any_q;
    if (clear_i) begin
      max_d = '0;
      idx_d = '0;
      any_d = 1'b0;
    end else if (en_i) begin
      any_d = 1'b1;
      if (!any_q || (mag_i > max_q)) begin
        max_d = mag_i;
        idx_d = idx_i;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      max_q <= '0;
      idx_q <= '0;
      any_q <= 1'b0;
    end else begin
      max_q <= max_d;
      idx_q <= idx_d;
      any_q <= any_d;
    end
  end

  assign max_o = max_q;
  assign idx_o = idx_q;
  assign any_o = any_q;

endmodule

// File: rtl/ltf_sync_ctrl.sv
// LTF timing-sync controller: flush, windowed peak search, optional
// second-peak confirmation (macro LTF_SYNC_CONFIRM_EN).
module ltf_sync_ctrl
  import ltf_sync_pkg::*;
#(
  parameter int MAG_WIDTH    = MAG_WIDTH_DEF,
  parameter int CORR_LATENCY = CORR_LATENCY_DEF,
  parameter int WINDOW       = WINDOW_DEF,
  parameter int SPACING      = SPACING_DEF,
  parameter int TOL          = TOL_DEF,
  parameter int IDX_WIDTH    = IDX_WIDTH_DEF
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 arm_i,
  input  logic                 abort_i,
  input  logic                 valid_i,
  input  logic [MAG_WIDTH-1:0] mag_i,
  input  logic [MAG_WIDTH-1:0] threshold_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 found_o,
  output logic [IDX_WIDTH-1:0] peak_idx_o,
  output logic [MAG_WIDTH-1:0] peak_mag_o
);

  localparam int FW = cnt_bits(CORR_LATENCY);
  localparam int WW = cnt_bits(WINDOW);

  state_e               state_q, state_d;
  logic [FW-1:0]        flush_cnt_q, flush_cnt_d;
  logic [IDX_WIDTH-1:0] blk_q, blk_d;
  logic [WW-1:0]        win_q, win_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 found_q, found_d;
  logic [IDX_WIDTH-1:0] pidx_q, pidx_d;
  logic [MAG_WIDTH-1:0] pmag_q, pmag_d;

  logic                 qual;
  logic                 win_done;
  logic                 trk_clear;
  logic                 trk_en;
  logic                 trk_any;
  logic                 fin;
  logic                 fin_found;
  logic [IDX_WIDTH-1:0] blk_inc;
  logic [IDX_WIDTH-1:0] trk_idx;
  logic [MAG_WIDTH-1:0] trk_max;

  assign qual      = mag_i >= threshold_i;
  assign win_done  = win_q == WW'(WINDOW);
  assign blk_inc   = (&blk_q) ? blk_q : blk_q + IDX_WIDTH'(1);
  assign trk_clear = (state_q == IDLE) || (state_q == FLUSH);
  assign trk_en    = (state_q == SEARCH) && !win_done && valid_i && qual;

  ltf_peak_tracker #(
    .MAG_WIDTH(MAG_WIDTH),
    .IDX_WIDTH(IDX_WIDTH)
  ) u_trk (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .clear_i(trk_clear),
    .en_i   (trk_en),
    .mag_i  (mag_i),
    .idx_i  (blk_q),
    .max_o  (trk_max),
    .idx_o  (trk_idx),
    .any_o  (trk_any)
  );

`ifdef LTF_SYNC_CONFIRM_EN
  localparam int LO_OFF = SPACING - TOL;
  localparam int HI_OFF = SPACING + TOL;

  logic               conf;
  logic signed [31:0] dist;

  // Distance of the next block index from the held first peak.
  assign dist = $signed(32'(blk_q)) - $signed(32'(trk_idx));
`endif

  always_comb begin
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    blk_d       = blk_q;
    win_d       = win_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    found_d     = found_q;
    pidx_d      = pidx_q;
    pmag_d      = pmag_q;
    fin         = 1'b0;
    fin_found   = 1'b0;
`ifdef LTF_SYNC_CONFIRM_EN
    conf        = 1'b0;
`endif

    unique case (state_q)
      IDLE: begin
        if (arm_i) begin
          state_d     = FLUSH;
          flush_cnt_d = '0;
          busy_d      = 1'b1;
        end
      end
      FLUSH: begin
        if ((CORR_LATENCY == 0) ||
            (valid_i && (flush_cnt_q == FW'(CORR_LATENCY - 1)))) begin
          state_d = SEARCH;
          blk_d   = '0;
          win_d   = '0;
        end else if (valid_i) begin
          flush_cnt_d = flush_cnt_q + FW'(1);
        end
      end
      SEARCH: begin
        if (!win_done) begin
          if (valid_i) begin
            blk_d = blk_inc;
            win_d = win_q + WW'(1);
          end
        end else begin
`ifdef LTF_SYNC_CONFIRM_EN
          if (!trk_any) begin
            fin = 1'b1;
          end else begin
            state_d = CONFIRM;
            conf    = 1'b1;
          end
`else
          fin       = 1'b1;
          fin_found = trk_any;
`endif
        end
      end
`ifdef LTF_SYNC_CONFIRM_EN
      CONFIRM: begin
        conf = 1'b1;
      end
`endif
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

`ifdef LTF_SYNC_CONFIRM_EN
    // The block arriving in the end-of-window cycle already belongs here.
    if (conf) begin
      if (dist > HI_OFF) begin
        fin = 1'b1;
      end else if (valid_i) begin
        blk_d = blk_inc;
        if (qual && (dist >= LO_OFF)) begin
          fin       = 1'b1;
          fin_found = 1'b1;
        end else if (dist == HI_OFF) begin
          fin = 1'b1;
        end
      end
    end
`endif

    if (fin) begin
      state_d = DONE;
      busy_d  = 1'b0;
      done_d  = 1'b1;
      found_d = fin_found;
      pidx_d  = fin_found ? trk_idx : '0;
      pmag_d  = fin_found ? trk_max : '0;
    end

    if (abort_i && (state_q != IDLE)) begin
      state_d = IDLE;
      busy_d  = 1'b0;
      done_d  = 1'b0;
      found_d = found_q;
      pidx_d  = pidx_q;
      pmag_d  = pmag_q;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      flush_cnt_q <= '0;
      blk_q       <= '0;
      win_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      found_q     <= 1'b0;
      pidx_q      <= '0;
      pmag_q      <= '0;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
      blk_q       <= blk_d;
      win_q       <= win_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      found_q     <= found_d;
      pidx_q      <= pidx_d;
      pmag_q      <= pmag_d;
    end
  end

  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign found_o    = found_q;
  assign peak_idx_o = pidx_q;
  assign peak_mag_o = pmag_q;

endmodule
